// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO.
//
// Generic width and depth. Programmable almost-full and almost-empty thresholds.
// Live occupancy count. Sticky overflow and underflow error flags.
//
// Build option:
//   FIFO_FWFT_EN  When defined, the FIFO runs in first-word-fall-through mode: buf_out_o shows
//                 the head entry combinationally whenever the FIFO is not empty.
//                 When undefined, the FIFO runs in standard mode: buf_out_o is a register that
//                 loads the head entry on each accepted read, so reads have 1-cycle latency.
//
// Ports:
//   clk_i           clock; all logic runs on the rising edge
//   rst_i           asynchronous active-high reset
//   wr_en_i         write request
//   buf_in_i        write data
//   rd_en_i         read (pop) request
//   err_clr_i       synchronous clear of the overflow and underflow flags
//   buf_out_o       read data
//   buf_empty_o     count == 0
//   buf_full_o      count == DEPTH
//   almost_empty_o  count <= AE_THRESH
//   almost_full_o   count >= AF_THRESH
//   fifo_count_o    occupancy, 0..DEPTH
//   overflow_o      sticky flag: a write was attempted while the FIFO was full
//   underflow_o     sticky flag: a read was attempted while the FIFO was empty
module fifo_sync_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] buf_in_i,
  input  logic              rd_en_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] buf_out_o,
  output logic              buf_empty_o,
  output logic              buf_full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   fifo_count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  // Acceptance is judged against the registered flags, so a full FIFO drops a write
  // even when a read is accepted in the same cycle.
  assign wr_acc = wr_en_i & ~full_q;
  assign rd_acc = rd_en_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural ADDR_W-bit overflow gives the wrap to 0.
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Status flags are registered from the next count, so they are valid right after the edge.
  always_comb begin
    empty_d = (count_d == '0);
    full_d  = (count_d == CntW'(DEPTH));
    ae_d    = (count_d <= CntW'(AE_THRESH));
    af_d    = (count_d >= CntW'(AF_THRESH));
    // A new error event wins over a clear in the same cycle.
    ovf_d   = (wr_en_i & full_q) | (ovf_q & ~err_clr_i);
    unf_d   = (rd_en_i & empty_q) | (unf_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= buf_in_i;
  end

`ifdef FIFO_FWFT_EN
  // The head entry falls through to the output. Forcing 0 while empty keeps the
  // post-reset value defined without a data register.
  assign buf_out_o = empty_q ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] buf_out_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_out_q <= '0;
    end else if (rd_acc) begin
      buf_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign buf_out_o = buf_out_q;
`endif

  assign buf_empty_o    = empty_q;
  assign buf_full_o     = full_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;
  assign fifo_count_o   = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DATA_W=8, DEPTH=16, AF=12, AE=2).
// The stimulus side keeps a reference queue. For every read it expects to be accepted, it
// pushes the expected word onto exp_q. The monitor pops exp_q and compares whenever the DUT
// completes a read handshake.
module tb_fifo_sync_param;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i, rd_en_i, err_clr_i;
  logic [7:0] buf_in_i, buf_out_o;
  logic       buf_empty_o, buf_full_o, almost_empty_o, almost_full_o;
  logic [4:0] fifo_count_o;
  logic       overflow_o, underflow_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  fifo_sync_param #(
    .DATA_W   (8),
    .DEPTH    (16),
    .AF_THRESH(12),
    .AE_THRESH(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (wr_en_i),
    .buf_in_i      (buf_in_i),
    .rd_en_i       (rd_en_i),
    .err_clr_i     (err_clr_i),
    .buf_out_o     (buf_out_o),
    .buf_empty_o   (buf_empty_o),
    .buf_full_o    (buf_full_o),
    .almost_empty_o(almost_empty_o),
    .almost_full_o (almost_full_o),
    .fifo_count_o  (fifo_count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all status outputs against values derived from an occupancy count.
  task automatic check_status(input string tag, input int cnt);
    check({tag, " count"}, 32'(fifo_count_o), 32'(cnt));
    check({tag, " empty"}, 32'(buf_empty_o), 32'(cnt == 0));
    check({tag, " full"}, 32'(buf_full_o), 32'(cnt == 16));
    check({tag, " almost_empty"}, 32'(almost_empty_o), 32'(cnt <= 2));
    check({tag, " almost_full"}, 32'(almost_full_o), 32'(cnt >= 12));
    check({tag, " overflow"}, 32'(overflow_o), 32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow_o), 32'(m_unf));
  endtask

  // Drive one clock of stimulus, starting 1 time unit after a rising edge.
  task automatic cycle(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
    bit full_m;
    bit empty_m;
    full_m  = (model.size() == 16);
    empty_m = (model.size() == 0);
    wr_en_i   = wr;
    buf_in_i  = din;
    rd_en_i   = rd;
    err_clr_i = clr;
    if (rd && !empty_m) exp_q.push_back(model.pop_front());
    if (wr && !full_m) model.push_back(din);
    if (wr && full_m) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (rd && empty_m) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
    @(posedge clk_i);
    #1;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    err_clr_i = 1'b0;
  endtask

  // Monitor: compares read data whenever the DUT completes a read handshake.
  bit pending = 1'b0;

  task automatic compare_pop();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_read: got 0x%0h, expected no read at %0t", buf_out_o, $time);
    end else begin
      e = exp_q.pop_front();
      check("read_data", 32'(buf_out_o), 32'(e));
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      pending = 1'b0;
    end else begin
`ifdef FIFO_FWFT_EN
      if (rd_en_i && !buf_empty_o) compare_pop();
`else
      if (pending) compare_pop();
      pending = rd_en_i && !buf_empty_o;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    err_clr_i = 1'b0;
    buf_in_i = 8'h00;
    @(posedge clk_i);
    #1;
    check_status("reset", 0);
    check("reset buf_out", 32'(buf_out_o), 32'h0);
    rst_i = 1'b0;

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      check_status("fill", i);
    end
    check("full count", 32'(fifo_count_o), 32'd16);

    // Overflow, with set taking priority over a same-cycle clear.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf set", 32'(overflow_o), 32'd1);
    check("ovf count", 32'(fifo_count_o), 32'd16);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    check("ovf set beats clr", 32'(overflow_o), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf cleared", 32'(overflow_o), 32'd0);

    // Drain all 16 words; the monitor checks 0x01..0x10 in order.
    for (int i = 15; i >= 0; i--) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check_status("drain", i);
    end

    // Underflow on an empty FIFO.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("underflow", 0);
    check("unf set", 32'(underflow_o), 32'd1);
`ifndef FIFO_FWFT_EN
    check("unf buf_out held", 32'(buf_out_o), 32'h10);
`endif

    // Count 5, then 20 simultaneous read/write cycles that wrap the pointers.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
      check("steady count", 32'(fifo_count_o), 32'd5);
    end

    // Fill to 16, then read and write together while full.
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check_status("refill", 16);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full rw count", 32'(fifo_count_o), 32'd15);
    check("full rw ovf", 32'(overflow_o), 32'd1);
    for (int i = 14; i >= 0; i--) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("drain2", 0);

    // Asynchronous reset in the middle of a burst, with rd_en held high.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    rd_en_i = 1'b1;
    wr_en_i = 1'b1;
    buf_in_i = 8'h63;
    #1 rst_i = 1'b1;
    #1;
    model.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_status("async reset", 0);
    check("async reset buf_out", 32'(buf_out_o), 32'h0);
    rd_en_i = 1'b0;
    wr_en_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check_status("post reset write", 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    check("post reset read", 32'(buf_out_o), 32'h55);
`endif
    check_status("post reset read", 0);

    // Single word into an empty FIFO.
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check("single empty", 32'(buf_empty_o), 32'd0);
`ifdef FIFO_FWFT_EN
    check("fwft fall-through", 32'(buf_out_o), 32'h3C);
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("single read empty", 32'(buf_empty_o), 32'd1);
`ifndef FIFO_FWFT_EN
    check("single read data", 32'(buf_out_o), 32'h3C);
`endif

    // Let the monitor consume any outstanding expectation.
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
